syn_accum: RTL and testbench
============================

// Module: syn_accum
// PURPOSE
//  Per-timestep synaptic accumulator; directly upstream of the spike/threshold stage.
//  On each i_start it scans NUM_SYN synapses, one per clock, and accumulates the weights of
//  active synapses into separate excitatory and inhibitory sums. It also computes the leak
//  term from the fed-back membrane voltage.
//  Produces the 14-bit excit, inhibit and cond_decay operands consumed by the spike stage.
// PARAMETERS
//  NUM_SYN      8   number of synapses scanned per timestep (>=2)
//  WEIGHT_W     12  weight width; weights are unsigned and zero-extended to 14 bits
//  DECAY_SHIFT  3   leak shift: cond_decay = v - (v >> DECAY_SHIFT)
// PORTS
//  clk              in   1              clock, rising edge
//  reset            in   1              asynchronous active-low reset
//  i_start          in   1              begin timestep; honoured only in IDLE
//  i_spikes         in   NUM_SYN        presynaptic spike vector; sampled on the start edge
//  i_voltage        in   14             membrane voltage fed back from the spike stage
//  i_wr_en          in   1              weight table write strobe
//  i_wr_addr        in   $clog2(NUM_SYN) synapse index to write
//  i_wr_weight      in   WEIGHT_W       weight magnitude
//  i_wr_inhib       in   1              1 = inhibitory synapse, 0 = excitatory
//  o_sum_excit      out  14             excitatory sum
//  o_sum_inhibit    out  14             inhibitory sum
//  o_cond_decay     out  14             leaked voltage term
//  o_valid          out  1              one-cycle pulse: outputs updated
//  o_busy           out  1              high outside IDLE
//  o_sat            out  1              an accumulator clamped this timestep
// BEHAVIOUR
//  - Reset (async, active-low): FSM=IDLE; all outputs 0; accumulators 0; weight table
//    cleared to weight 0, excitatory.
//  - FSM states: IDLE -> SCAN -> DONE -> IDLE.
//  - IDLE, start edge (edge 0), with i_start=1:
//    latch i_spikes and i_voltage; clear accumulators and index; go to SCAN.
//  - SCAN, edges 1..NUM_SYN: edge k processes synapse k-1.
//    - Spike bit set: its weight is added to the excit or inhib accumulator, per its inhib flag.
//    - Spike bit clear: nothing is added.
//    - After index NUM_SYN-1 the FSM goes to DONE.
//  - DONE, edge NUM_SYN+1:
//    - Register o_sum_excit, o_sum_inhibit and o_cond_decay, and set o_valid=1 for exactly one cycle.
//    - o_cond_decay is computed from the latched voltage.
//    - Return to IDLE.
//  - Latency: o_valid is high during the cycle after edge NUM_SYN+1.
//    A new i_start is accepted on the next edge, i.e. back-to-back timesteps are possible.
//  - Outputs hold their values between o_valid pulses. o_sat is updated together with the outputs.
//  - i_start while o_busy=1 is ignored; there is no queueing.
//    Changes to i_spikes or i_voltage after the start edge have no effect on the running timestep.
//  - Weight writes are accepted in any state and take effect on the following edge.
//    A SCAN edge reads the pre-write value of the entry it processes.
//  - An i_wr_addr >= NUM_SYN is ignored.
//  - Arithmetic: unsigned 14-bit accumulation; o_cond_decay is always <= i_voltage
//    and cannot underflow.
//  - Reset asserted mid-SCAN aborts the timestep: no o_valid, and the state is as after reset.
// CONFIGURATION
//  SYN_ACC_SAT_EN defined:
//    - Each accumulator add saturates at 14'h3FFF.
//    - o_sat=1 at DONE if either accumulator clamped during the timestep.
//  SYN_ACC_SAT_EN undefined:
//    - Adds wrap modulo 2^14.
//    - o_sat is tied to 0.
// TESTING
//  1. Use NUM_SYN=8 and a 4-cycle reset.
//     -> All outputs are 0, o_busy=0, and a scan of all 8 spikes gives sums 0.
//  2. Set w0=0x040 excitatory and w1=0x020 inhibitory; spikes=8'h03; voltage=0x0800.
//     -> o_valid at edge 9; excit=0x040, inhibit=0x020, decay=0x0700.
//  3. Set all weights to 0xFFF excitatory; spikes=8'hFF.
//     -> With the macro: excit=0x3FFF, o_sat=1. Without it: excit=0x3FF8, o_sat=0.
//  4. Pulse i_start again at edge 3 of an active scan.
//     -> It is ignored: a single o_valid at edge 9, and the results come from the first vector only.
//  5. Assert reset at edge 5 of a scan, then release it.
//     -> No o_valid; outputs are 0; the weight table is cleared; the next start sums 0.
//  6. Write w2=0x100 during SCAN edge 2, with spikes=8'h04.
//     -> excit=0x100, because entry 2 is read at edge 3 after the write.

Source files
------------

// File: rtl/syn_accum.sv
// Synaptic accumulator: scans NUM_SYN synapses per timestep into excit/inhibit sums plus leak term.
// Latency: o_valid pulses the cycle after edge NUM_SYN+1 from the accepted start; back-to-back starts OK.
// Backpressure: none; i_start outside IDLE is dropped. SYN_ACC_SAT_EN selects saturating adds + o_sat.
module syn_accum #(
    parameter int NUM_SYN     = 8,
    parameter int WEIGHT_W    = 12,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic [NUM_SYN-1:0]         i_spikes,
    input  logic [13:0]                i_voltage,
    input  logic                       i_wr_en,
    input  logic [$clog2(NUM_SYN)-1:0] i_wr_addr,
    input  logic [WEIGHT_W-1:0]        i_wr_weight,
    input  logic                       i_wr_inhib,
    output logic [13:0]                o_sum_excit,
    output logic [13:0]                o_sum_inhibit,
    output logic [13:0]                o_cond_decay,
    output logic                       o_valid,
    output logic                       o_busy,
    output logic                       o_sat
);
    localparam int IDX_W = $clog2(NUM_SYN);
    localparam int ACC_W = 14;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t state, state_nxt;
    logic   start_acc, scan_en, done_en, last_idx;

    logic [WEIGHT_W-1:0] w_mag [NUM_SYN];
    logic                w_inh [NUM_SYN];

    logic [NUM_SYN-1:0] spikes_q;
    logic [13:0]        volt_q;
    logic [IDX_W-1:0]   idx;
    logic [ACC_W-1:0]   acc_e, acc_i, nxt_e, nxt_i, cur_w;
    logic               hit, hit_inh;
`ifdef SYN_ACC_SAT_EN
    logic               sat_acc, clamp;
    logic [ACC_W:0]     sum_e, sum_i;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start)  state_nxt = S_SCAN;
            S_SCAN:  if (last_idx) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy    = (state != S_IDLE);
        start_acc = (state == S_IDLE) && i_start;
        scan_en   = (state == S_SCAN);
        done_en   = (state == S_DONE);
    end

    assign last_idx = (idx == IDX_W'(NUM_SYN - 1));

    // Writes land on the edge after the strobe; a scan edge sees the old entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                w_mag[i] <= '0;
                w_inh[i] <= 1'b0;
            end
        end else if (i_wr_en && ({1'b0, i_wr_addr} < (IDX_W+1)'(NUM_SYN))) begin
            w_mag[i_wr_addr] <= i_wr_weight;
            w_inh[i_wr_addr] <= i_wr_inhib;
        end
    end

    always_comb begin
        cur_w   = ACC_W'(w_mag[idx]);
        hit     = spikes_q[idx];
        hit_inh = w_inh[idx];
`ifdef SYN_ACC_SAT_EN
        sum_e = {1'b0, acc_e} + {1'b0, cur_w};
        sum_i = {1'b0, acc_i} + {1'b0, cur_w};
        nxt_e = sum_e[ACC_W] ? 14'h3FFF : sum_e[ACC_W-1:0];
        nxt_i = sum_i[ACC_W] ? 14'h3FFF : sum_i[ACC_W-1:0];
        clamp = hit && (hit_inh ? sum_i[ACC_W] : sum_e[ACC_W]);
`else
        nxt_e = acc_e + cur_w;
        nxt_i = acc_i + cur_w;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spikes_q      <= '0;
            volt_q        <= '0;
            idx           <= '0;
            acc_e         <= '0;
            acc_i         <= '0;
            o_sum_excit   <= '0;
            o_sum_inhibit <= '0;
            o_cond_decay  <= '0;
            o_valid       <= 1'b0;
        end else begin
            o_valid <= done_en;
            if (start_acc) begin
                spikes_q <= i_spikes;
                volt_q   <= i_voltage;
                idx      <= '0;
                acc_e    <= '0;
                acc_i    <= '0;
            end else if (scan_en) begin
                idx <= idx + 1'b1;
                if (hit) begin
                    if (hit_inh) acc_i <= nxt_i;
                    else         acc_e <= nxt_e;
                end
            end
            if (done_en) begin
                o_sum_excit   <= acc_e;
                o_sum_inhibit <= acc_i;
                o_cond_decay  <= volt_q - (volt_q >> DECAY_SHIFT);
            end
        end
    end

`ifdef SYN_ACC_SAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_acc <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            if (start_acc)             sat_acc <= 1'b0;
            else if (scan_en && clamp) sat_acc <= 1'b1;
            if (done_en)               o_sat   <= sat_acc;
        end
    end
`else
    assign o_sat = 1'b0;
`endif

endmodule

// File: tb/tb_syn_accum.sv
// Randomized self-checking bench for syn_accum against an arithmetic reference of the weight table.
module tb_syn_accum;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_spikes = '0;
    logic [13:0] i_voltage = '0;
    logic        i_wr_en = 1'b0;
    logic [2:0]  i_wr_addr = '0;
    logic [11:0] i_wr_weight = '0;
    logic        i_wr_inhib = 1'b0;
    logic [13:0] o_sum_excit, o_sum_inhibit, o_cond_decay;
    logic        o_valid, o_busy, o_sat;

    int errors = 0;
    int checks = 0;
    int ref_w [8];
    bit ref_inh [8];

    syn_accum #(.NUM_SYN(8), .WEIGHT_W(12), .DECAY_SHIFT(3)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_spikes(i_spikes),
        .i_voltage(i_voltage), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_weight(i_wr_weight), .i_wr_inhib(i_wr_inhib),
        .o_sum_excit(o_sum_excit), .o_sum_inhibit(o_sum_inhibit),
        .o_cond_decay(o_cond_decay), .o_valid(o_valid), .o_busy(o_busy), .o_sat(o_sat)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [7:0] sp, input logic [13:0] v,
                                  output logic [13:0] e, output logic [13:0] ih,
                                  output logic [13:0] d, output logic s);
        int te = 0;
        int ti = 0;
        for (int k = 0; k < 8; k++)
            if (sp[k]) begin
                if (ref_inh[k]) ti += ref_w[k];
                else            te += ref_w[k];
            end
`ifdef SYN_ACC_SAT_EN
        e  = 14'((te > 16383) ? 16383 : te);
        ih = 14'((ti > 16383) ? 16383 : ti);
        s  = (te > 16383) || (ti > 16383);
`else
        e  = 14'(te % 16384);
        ih = 14'(ti % 16384);
        s  = 1'b0;
`endif
        d = 14'(int'(v) - int'(v) / 8);
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic wr(input int addr, input int w, input bit inh);
        i_wr_en = 1'b1; i_wr_addr = 3'(addr); i_wr_weight = 12'(w); i_wr_inhib = inh;
        @(posedge clk); @(negedge clk);
        i_wr_en = 1'b0;
        ref_w[addr] = w; ref_inh[addr] = inh;
    endtask

    task automatic do_timestep(input logic [7:0] sp, input logic [13:0] v, input bit scramble,
                               output int lat, output logic [13:0] e, output logic [13:0] ih,
                               output logic [13:0] d, output logic s);
        i_start = 1'b1; i_spikes = sp; i_voltage = v;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        i_start = 1'b0;
        if (scramble) begin
            i_spikes = 8'($urandom); i_voltage = 14'($urandom);
        end
        while (!o_valid && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        e = o_sum_excit; ih = o_sum_inhibit; d = o_cond_decay; s = o_sat;
    endtask

    task automatic test_reset;
        logic [13:0] e, ih, d, xe, xi, xd; logic s, xs; int lat;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin ref_w[k] = 0; ref_inh[k] = 1'b0; end
        checks++;
        if ({o_sum_excit, o_sum_inhibit, o_cond_decay, o_valid, o_busy, o_sat} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got e=%h i=%h d=%h v=%b b=%b s=%b, want all 0",
                     o_sum_excit, o_sum_inhibit, o_cond_decay, o_valid, o_busy, o_sat);
        end
        do_timestep(8'hFF, 14'h0123, 1'b0, lat, e, ih, d, s);
        model(8'hFF, 14'h0123, xe, xi, xd, xs);
        checks++;
        if (lat !== 9 || e !== 14'h0 || ih !== 14'h0 || d !== xd || s !== 1'b0) begin
            errors++;
            $display("FAIL reset_scan: got lat=%0d e=%h i=%h d=%h s=%b, want lat=9 e=0 i=0 d=%h s=0",
                     lat, e, ih, d, s, xd);
        end
    endtask

    task automatic test_basic;
        logic [13:0] e, ih, d; logic s; int lat;
        wr(0, 12'h040, 1'b0);
        wr(1, 12'h020, 1'b1);
        do_timestep(8'h03, 14'h0800, 1'b1, lat, e, ih, d, s);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", lat); end
        checks++;
        if (e !== 14'h0040 || ih !== 14'h0020 || d !== 14'h0700 || s !== 1'b0) begin
            errors++;
            $display("FAIL basic_values: got e=%h i=%h d=%h s=%b, want 0040 0020 0700 0", e, ih, d, s);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_sum_excit !== 14'h0040) begin
            errors++;
            $display("FAIL basic_pulse_hold: got v=%b e=%h, want v=0 e=0040", o_valid, o_sum_excit);
        end
    endtask

    task automatic test_back_to_back;
        logic [13:0] e, ih, d, xe, xi, xd; logic s, xs; int lat;
        logic [7:0] sp; logic [13:0] v;
        for (int k = 0; k < 8; k++) wr(k, int'($urandom_range(0, 4095)), 1'($urandom));
        for (int n = 0; n < 3; n++) begin
            sp = 8'($urandom); v = 14'($urandom);
            model(sp, v, xe, xi, xd, xs);
            do_timestep(sp, v, 1'b1, lat, e, ih, d, s);
            checks++;
            if (lat !== 9 || e !== xe || ih !== xi || d !== xd || s !== xs) begin
                errors++;
                $display("FAIL b2b_%0d: got lat=%0d e=%h i=%h d=%h s=%b, want lat=9 e=%h i=%h d=%h s=%b",
                         n, lat, e, ih, d, s, xe, xi, xd, xs);
            end
        end
    endtask

    task automatic test_start_ignored;
        logic [13:0] xe, xi, xd, ge, gi, gd; logic xs;
        int nval = 0; int first = 0;
        logic [7:0] sp_a; logic [13:0] v_a;
        sp_a = 8'h5A; v_a = 14'(int'($urandom_range(0, 16383)));
        model(sp_a, v_a, xe, xi, xd, xs);
        ge = '0; gi = '0; gd = '0;
        i_start = 1'b1; i_spikes = sp_a; i_voltage = v_a;
        @(posedge clk); @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_in_scan: got %b want 1", o_busy); end
        for (int c = 1; c <= 22; c++) begin
            if (c == 3) begin i_start = 1'b1; i_spikes = ~sp_a; i_voltage = ~v_a; end
            @(posedge clk); @(negedge clk);
            i_start = 1'b0;
            if (o_valid) begin
                nval++;
                if (nval == 1) begin
                    first = c; ge = o_sum_excit; gi = o_sum_inhibit; gd = o_cond_decay;
                end
            end
        end
        checks++;
        if (nval !== 1 || first !== 9) begin
            errors++;
            $display("FAIL start_ignored_count: got %0d pulses first at %0d, want 1 at 9", nval, first);
        end
        checks++;
        if (ge !== xe || gi !== xi || gd !== xd) begin
            errors++;
            $display("FAIL start_ignored_values: got e=%h i=%h d=%h, want e=%h i=%h d=%h",
                     ge, gi, gd, xe, xi, xd);
        end
    endtask

    task automatic test_wr_during_scan;
        int nval = 0; logic [13:0] ge, gi;
        wr(2, 12'h055, 1'b0);
        wr(3, 12'h011, 1'b0);
        ge = '0; gi = '0;
        i_start = 1'b1; i_spikes = 8'h0C; i_voltage = 14'h0100;
        @(posedge clk); @(negedge clk);
        i_start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            // Entry 2 is read at edge 3 (after the edge-2 write); entry 3 at edge 4 (same edge as its write).
            if (c == 2) begin i_wr_en = 1'b1; i_wr_addr = 3'd2; i_wr_weight = 12'h100; i_wr_inhib = 1'b0; end
            if (c == 4) begin i_wr_en = 1'b1; i_wr_addr = 3'd3; i_wr_weight = 12'h222; i_wr_inhib = 1'b0; end
            @(posedge clk); @(negedge clk);
            i_wr_en = 1'b0;
            if (o_valid) begin nval++; ge = o_sum_excit; gi = o_sum_inhibit; end
        end
        ref_w[2] = 12'h100; ref_inh[2] = 1'b0;
        ref_w[3] = 12'h222; ref_inh[3] = 1'b0;
        checks++;
        if (nval !== 1 || ge !== 14'h0111 || gi !== 14'h0000) begin
            errors++;
            $display("FAIL wr_during_scan: got pulses=%0d e=%h i=%h, want 1 0111 0000", nval, ge, gi);
        end
    endtask

    task automatic test_random;
        logic [13:0] e, ih, d, xe, xi, xd; logic s, xs; int lat;
        logic [7:0] sp; logic [13:0] v;
        for (int n = 0; n < 12; n++) begin
            for (int w = 0; w < 3; w++)
                wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)), 1'($urandom));
            sp = 8'($urandom); v = 14'($urandom);
            model(sp, v, xe, xi, xd, xs);
            do_timestep(sp, v, 1'b1, lat, e, ih, d, s);
            checks++;
            if (lat !== 9 || e !== xe || ih !== xi || d !== xd || s !== xs) begin
                errors++;
                $display("FAIL random_%0d: got lat=%0d e=%h i=%h d=%h s=%b, want lat=9 e=%h i=%h d=%h s=%b",
                         n, lat, e, ih, d, s, xe, xi, xd, xs);
            end
        end
    endtask

    task automatic test_saturation;
        logic [13:0] e, ih, d, want_e; logic s, want_s; int lat;
        for (int k = 0; k < 8; k++) wr(k, 12'hFFF, 1'b0);
`ifdef SYN_ACC_SAT_EN
        want_e = 14'h3FFF; want_s = 1'b1;
`else
        want_e = 14'h3FF8; want_s = 1'b0;
`endif
        do_timestep(8'hFF, 14'h3FFF, 1'b0, lat, e, ih, d, s);
        checks++;
        if (lat !== 9 || e !== want_e || ih !== 14'h0 || s !== want_s || d !== 14'h3800) begin
            errors++;
            $display("FAIL saturation: got lat=%0d e=%h i=%h d=%h s=%b, want lat=9 e=%h i=0 d=3800 s=%b",
                     lat, e, ih, d, s, want_e, want_s);
        end
    endtask

    task automatic test_reset_abort;
        logic [13:0] e, ih, d; logic s; int lat; int nval = 0;
        i_start = 1'b1; i_spikes = 8'hFF; i_voltage = 14'h1234;
        @(posedge clk); @(negedge clk);
        i_start = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        reset = 1'b0;
        #1;
        checks++;
        if ({o_sum_excit, o_sum_inhibit, o_cond_decay, o_valid, o_busy, o_sat} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got e=%h i=%h d=%h v=%b b=%b s=%b, want all 0",
                     o_sum_excit, o_sum_inhibit, o_cond_decay, o_valid, o_busy, o_sat);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin ref_w[k] = 0; ref_inh[k] = 1'b0; end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            if (o_valid) nval++;
        end
        checks++;
        if (nval !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", nval); end
        do_timestep(8'hFF, 14'h0000, 1'b0, lat, e, ih, d, s);
        checks++;
        if (lat !== 9 || e !== 14'h0 || ih !== 14'h0 || d !== 14'h0 || s !== 1'b0) begin
            errors++;
            $display("FAIL abort_table_cleared: got lat=%0d e=%h i=%h d=%h s=%b, want lat=9 all 0",
                     lat, e, ih, d, s);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_ignored();
        test_wr_during_scan();
        test_random();
        test_saturation();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
